// File: rtl/excl_grant_pkg.sv
// Shared types and limits for the exclusive-grant round-robin arbiter.
package excl_grant_pkg;
  localparam int NREQ_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/excl_grant_arb_rr_pick.sv
// Combinational cyclic first-set search starting at ptr, skipping masked requesters.
module rr_pick
  import excl_grant_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] sel,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    logic [IDXW-1:0] jj;
    sel = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDXW'(j);
      if (!any && req[jj] && !mask[jj]) begin
        any     = 1'b1;
        sel[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/excl_grant_arb.sv
// Round-robin arbiter with a registered one-hot grant held until out_valid & out_ready.
// Optional sticky protocol checker enabled by defining EXCL_GRANT_CHECK_EN.
module excl_grant_arb
  import excl_grant_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NREQ-1:0] out_sel,
  output logic [IDXW-1:0] out_idx,
  output logic            err,
  output state_t          state_dbg,
  output logic [IDXW-1:0] rr_ptr_dbg
);

  // Handshake: a transfer fires on a cycle where out_valid and out_ready are both
  // high; the grant is frozen until then and req_ready mirrors the fired select.
  state_t          state, state_nxt;
  logic [NREQ-1:0] sel_nxt;
  logic [IDXW-1:0] idx_nxt, rr_ptr, ptr_nxt, idx_inc;
  logic [NREQ-1:0] pick_mask, pick_sel;
  logic [IDXW-1:0] pick_ptr, pick_idx;
  logic            pick_any, fire;

  assign fire    = (state == HOLD) && out_ready;
  assign idx_inc = (out_idx == IDXW'(NREQ - 1)) ? '0 : out_idx + 1'b1;

  // One picker serves both paths: from rr_ptr in IDLE, or past the fired index in HOLD.
  assign pick_mask = (state == HOLD) ? out_sel : '0;
  assign pick_ptr  = (state == HOLD) ? idx_inc : rr_ptr;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req  (req_valid),
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .sel  (pick_sel),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      out_sel <= '0;
      out_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      out_sel <= sel_nxt;
      out_idx <= idx_nxt;
      rr_ptr  <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = out_sel;
    idx_nxt   = out_idx;
    ptr_nxt   = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = HOLD;
          sel_nxt   = pick_sel;
          idx_nxt   = pick_idx;
        end
      end
      HOLD: begin
        if (fire) begin
          ptr_nxt = idx_inc;
          if (pick_any) begin
            sel_nxt = pick_sel;
            idx_nxt = pick_idx;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            idx_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == HOLD);
    req_ready  = fire ? out_sel : '0;
    state_dbg  = state;
    rr_ptr_dbg = rr_ptr;
  end

`ifdef EXCL_GRANT_CHECK_EN
  logic err_q;
  logic err_now;

  assign err_now = ($countones(out_sel) > 1)
                 || (out_valid && (out_sel == '0))
                 || ((state == HOLD) && !req_valid[out_idx] && !fire);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_q | err_now;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_excl_grant_arb.sv
// Directed self-checking bench for excl_grant_arb (NREQ=3), err expectations follow EXCL_GRANT_CHECK_EN.
module tb_excl_grant_arb;
  import excl_grant_pkg::*;

  localparam int NREQ = 3;
  localparam int IDXW = 2;
`ifdef EXCL_GRANT_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [NREQ-1:0] out_sel;
  logic [IDXW-1:0] out_idx;
  logic            err;
  state_t          state_dbg;
  logic [IDXW-1:0] rr_ptr_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  excl_grant_arb #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel),
    .out_idx    (out_idx),
    .err        (err),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [NREQ-1:0] sel, input logic [IDXW-1:0] idx);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sel"}, 32'(out_sel), 32'(sel));
    check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_onehot"}, 32'($countones(out_sel)), 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sel"}, 32'(out_sel), 32'd0);
    check({tag, "_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    logic [IDXW-1:0] exp_idx [5];
    logic [NREQ-1:0] exp_sel [5];
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    exp_sel = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    reset_n   = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_cleared("rst_hold");
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_ptr", 32'(rr_ptr_dbg), 32'd0);
    reset_n = 1'b1;

    // No requests for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_sel", 32'(out_sel), 32'd0);
      check("idle_err", 32'(err), 32'd0);
    end

    // Single request, ready already high: 1-cycle latency and immediate fire.
    req_valid = 3'b010;
    out_ready = 1'b1;
    #1;
    check("single_pre_valid", 32'(out_valid), 32'd0);
    tick();
    check_grant("single", 3'b010, 2'd1);
    check("single_ready", 32'(req_ready), 32'b010);
    check("single_ptr_before", 32'(rr_ptr_dbg), 32'd0);
    tick();
    req_valid = 3'b000;
    #1;
    check("single_after_valid", 32'(out_valid), 32'd0);
    check("single_ptr_after", 32'(rr_ptr_dbg), 32'd2);
    check("single_state", 32'(state_dbg), 32'(IDLE));

    // Restart from rr_ptr=0, then all requesters held: 0,1,2,0,1 with no bubbles.
    reset_n = 1'b0;
    #1;
    check_cleared("rst2");
    reset_n   = 1'b1;
    req_valid = 3'b111;
    out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_grant($sformatf("rr%0d", g), exp_sel[g], exp_idx[g]);
      check($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(exp_sel[g]));
    end

    // Grant idx 2 and stall it while other requesters change.
    tick();
    check_grant("stall_grant", 3'b100, 2'd2);
    out_ready = 1'b0;
    req_valid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_grant($sformatf("stall%0d", c), 3'b100, 2'd2);
      check($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("stall_fire_ready", 32'(req_ready), 32'b100);
    tick();
    check_grant("after_stall", 3'b001, 2'd0);
    check("after_stall_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("after_stall_err", 32'(err), 32'(ERR_ON));

    // Asynchronous reset in the middle of a held grant.
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_cleared("rst_mid");
    check("rst_mid_err", 32'(err), 32'd0);
    req_valid = 3'b100;
    #2;
    reset_n = 1'b1;
    tick();
    check_grant("post_rst", 3'b100, 2'd2);

    // Granted requester withdraws before fire.
    reset_n = 1'b0;
    #1;
    reset_n   = 1'b1;
    req_valid = 3'b010;
    out_ready = 1'b0;
    tick();
    check_grant("drop_grant", 3'b010, 2'd1);
    check("drop_err_pre", 32'(err), 32'd0);
    req_valid = 3'b000;
    tick();
    check("drop_err", 32'(err), 32'(ERR_ON));
    check_grant("drop_held", 3'b010, 2'd1);
    repeat (3) tick();
    check("drop_err_sticky", 32'(err), 32'(ERR_ON));
    out_ready = 1'b1;
    tick();
    check("drop_err_after_fire", 32'(err), 32'(ERR_ON));
    check("drop_idle", 32'(out_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("drop_err_reset", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
